// File: rtl/digital_clock_top.sv
// rtl/digital_clock_top.sv - 24-hour BCD time-of-day counter with one-second prescaler
//
// Purpose:
//   Free-running hh:mm:ss counter. Each field is two-digit packed BCD so it
//   can drive a display decoder directly. A prescaler divides clk down to a
//   one-cycle-wide tick every CLK_PER_SEC cycles. Seconds, minutes and hours
//   advance as a cascade on that tick.
//
// Parameters:
//   CLK_PER_SEC  clk cycles per one-second tick (>= 1; 1 ticks every cycle)
//   CNT_W        prescaler width, 2**CNT_W >= CLK_PER_SEC
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous active-high reset, clears prescaler and time
//   hour    out  8  packed BCD 0x00-0x23
//   minute  out  8  packed BCD 0x00-0x59
//   second  out  8  packed BCD 0x00-0x59

module digital_clock_top #(
  parameter int CLK_PER_SEC = 1,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] prescaler;
  logic             tick;
  logic             carry_s;
  logic             carry_m;
  logic [7:0]       second_next;
  logic [7:0]       minute_next;
  logic [7:0]       hour_next;

  // Mod-60 packed BCD increment: units roll 9->0 into tens, 59 wraps to 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd9) begin
      r = {v[7:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd5) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  // Mod-24 packed BCD increment: 23 wraps to 00 before the units rule,
  // since 23 -> 24 would otherwise be a legal-looking BCD step.
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // With CLK_PER_SEC = 1 PRE_LAST is 0 and the prescaler sits at 0, so the
  // tick is asserted every cycle out of reset.
  assign tick = (prescaler == PRE_LAST);

  // Carries are combinational so a rollover ripples through every field on
  // the same edge; 23:59:59 -> 00:00:00 shows no intermediate value.
  assign carry_s = tick && (second == 8'h59);
  assign carry_m = carry_s && (minute == 8'h59);

  always_comb begin
    second_next = bcd_inc60(second);
    minute_next = bcd_inc60(minute);
    hour_next   = bcd_inc24(hour);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      second    <= 8'h00;
      minute    <= 8'h00;
      hour      <= 8'h00;
    end else begin
      if (tick) begin
        prescaler <= '0;
        second    <= second_next;
      end else begin
        prescaler <= prescaler + CNT_W'(1);
      end
      if (carry_s) begin
        minute <= minute_next;
      end
      if (carry_m) begin
        hour <= hour_next;
      end
    end
  end

endmodule

// File: tb/tb_digital_clock_top.sv
// tb/tb_digital_clock_top.sv - randomized self-checking bench for digital_clock_top
//
// Two instances share one 20 ns clock: dut1 ticks every cycle, dut4 every
// fourth cycle. The reference model counts edges since reset release and
// derives the expected time with plain integer arithmetic.

module tb_digital_clock_top;

  logic       clk;
  logic       rst1;
  logic       rst4;
  logic [7:0] hour1, minute1, second1;
  logic [7:0] hour4, minute4, second4;

  int checks = 0;
  int errors = 0;

  digital_clock_top #(.CLK_PER_SEC(1), .CNT_W(32)) dut1 (
    .clk   (clk),
    .rst   (rst1),
    .hour  (hour1),
    .minute(minute1),
    .second(second1)
  );

  digital_clock_top #(.CLK_PER_SEC(4), .CNT_W(8)) dut4 (
    .clk   (clk),
    .rst   (rst4),
    .hour  (hour4),
    .minute(minute4),
    .second(second4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [23:0] to_bcd(input int secs);
    int s, h, m, x;
    s = secs % 86400;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fixed waypoints: edges after release -> expected {hour,minute,second}.
  int          spot_k [10] = '{1, 9, 10, 59, 60, 600, 3600, 36000, 86399, 86400};
  logic [23:0] spot_v [10] = '{24'h000001, 24'h000009, 24'h000010, 24'h000059,
                               24'h000100, 24'h001000, 24'h010000, 24'h100000,
                               24'h235959, 24'h000000};

  initial begin
    rst1 = 1'b1;
    rst4 = 1'b1;
    fork
      begin : run_dut1
        int  tot;
        bit  r;
        repeat (5) begin
          step();
          check("rst_hold", {hour1, minute1, second1}, 24'h000000);
        end
        rst1 = 1'b0;
        for (int k = 1; k <= 86400; k++) begin
          step();
          check("day", {hour1, minute1, second1}, to_bcd(k));
          for (int j = 0; j < 10; j++) begin
            if (spot_k[j] == k) check("spot", {hour1, minute1, second1}, spot_v[j]);
          end
        end
        for (int k = 1; k <= 125; k++) begin
          step();
          check("run125", {hour1, minute1, second1}, to_bcd(k));
        end
        check("at_0205", {hour1, minute1, second1}, 24'h000205);
        rst1 = 1'b1;
        step();
        check("mid_rst", {hour1, minute1, second1}, 24'h000000);
        rst1 = 1'b0;
        step();
        check("restart", {hour1, minute1, second1}, 24'h000001);
        tot = 1;
        repeat (3000) begin
          r = ($urandom_range(0, 39) == 0);
          rst1 = r;
          step();
          tot = r ? 0 : tot + 1;
          check("rand1", {hour1, minute1, second1}, to_bcd(tot));
        end
        rst1 = 1'b0;
      end
      begin : run_dut4
        int e;
        bit r;
        repeat (3) begin
          step();
          check("ps_rst_hold", {hour4, minute4, second4}, 24'h000000);
        end
        rst4 = 1'b0;
        e = 0;
        for (int i = 1; i <= 8; i++) begin
          step();
          e++;
          check("ps_model", {hour4, minute4, second4}, to_bcd(e / 4));
          if (e == 3) check("ps_edge3", {hour4, minute4, second4}, 24'h000000);
          if (e == 4) check("ps_edge4", {hour4, minute4, second4}, 24'h000001);
          if (e == 8) check("ps_edge8", {hour4, minute4, second4}, 24'h000002);
        end
        rst4 = 1'b1;
        step();
        check("ps_rst", {hour4, minute4, second4}, 24'h000000);
        rst4 = 1'b0;
        e = 0;
        for (int i = 1; i <= 5; i++) begin
          step();
          e++;
          check("ps_pre6", {hour4, minute4, second4}, to_bcd(e / 4));
        end
        rst4 = 1'b1;
        step();
        check("ps_rst6", {hour4, minute4, second4}, 24'h000000);
        rst4 = 1'b0;
        e = 0;
        for (int i = 1; i <= 4; i++) begin
          step();
          e++;
          check("ps_after6", {hour4, minute4, second4}, (i < 4) ? 24'h000000 : 24'h000001);
        end
        repeat (3000) begin
          r = ($urandom_range(0, 59) == 0);
          rst4 = r;
          step();
          e = r ? 0 : e + 1;
          check("rand4", {hour4, minute4, second4}, to_bcd(e / 4));
        end
        rst4 = 1'b0;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
